// File: rtl/mult_share_arb_if.sv
// Request/response bus for the shared multiplier.
//   master : requester side (drives req_valid/req_a/req_b, sees grant + response)
//   slave  : arbiter/multiplier side
// req_a/req_b pack requester i at bits [i*BWIDTH +: BWIDTH].
interface mult_share_arb_if #(
  parameter int BWIDTH = 64,
  parameter int NREQ   = 4,
  parameter int IDW    = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BWIDTH-1:0] req_a;
  logic [NREQ*BWIDTH-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic                   resp_valid;
  logic [IDW-1:0]         resp_id;
  logic [2*BWIDTH-1:0]    resp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter in front of one shared, 2-stage signed multiplier.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   halt      : blocks new grants; in-flight products still complete
//   bus       : request/response bus (slave side)
//   busy      : an operation sits in stage 1 or stage 2
//   op_count  : accepted requests since reset, wraps at 2^32
// A request accepted on edge E is presented with resp_valid on edge E+1.
module mult_share_arb #(
  parameter int BWIDTH = 64,
  parameter int NREQ   = 4,
  parameter int IDW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  mult_share_arb_if.slave   bus,
  output logic              busy,
  output logic [31:0]       op_count
);

  logic [IDW-1:0]             ptr;
  logic [IDW-1:0]             gnt_id;
  logic                       found;
  logic                       accept;

  logic                       s1_valid;
  logic [IDW-1:0]             s1_id;
  logic signed [BWIDTH-1:0]   s1_a;
  logic signed [BWIDTH-1:0]   s1_b;
  logic signed [2*BWIDTH-1:0] product;

  function automatic logic [IDW-1:0] wrap_idx(input int k);
    return IDW'(k % NREQ);
  endfunction

  // First valid requester at or after ptr, modulo NREQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[wrap_idx(int'(ptr) + i)]) begin
        found  = 1'b1;
        gnt_id = wrap_idx(int'(ptr) + i);
      end
    end
  end

  // The grant only ever points at a valid requester, so a grant is a transfer.
  assign accept        = found && !halt && !rst;
  assign bus.req_ready = accept ? (NREQ'(1) << gnt_id) : '0;

  assign product = s1_a * s1_b;
  assign busy    = s1_valid | bus.resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      op_count      <= '0;
      s1_valid      <= 1'b0;
      s1_id         <= '0;
      s1_a          <= '0;
      s1_b          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= '0;
    end else begin
      s1_valid       <= accept;
      bus.resp_valid <= s1_valid;
      if (accept) begin
        ptr      <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
        op_count <= op_count + 32'd1;
        s1_id    <= gnt_id;
        s1_a     <= bus.req_a[gnt_id*BWIDTH +: BWIDTH];
        s1_b     <= bus.req_b[gnt_id*BWIDTH +: BWIDTH];
      end
      // Response fields only move with a real product, so they hold otherwise.
      if (s1_valid) begin
        bus.resp_id   <= s1_id;
        bus.resp_data <= product;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: reset, single request, fairness,
// corner products, halt, reset mid-flight and counter wrap.
module tb_mult_share_arb;
  localparam int BW = 64;
  localparam int NR = 4;
  localparam int IW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        busy;
  logic [31:0] op_count;

  int nvec = 0;
  int nmis = 0;

  mult_share_arb_if #(.BWIDTH(BW), .NREQ(NR), .IDW(IW)) ifc ();

  mult_share_arb #(.BWIDTH(BW), .NREQ(NR), .IDW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .bus      (ifc.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    ifc.req_a[i*BW +: BW] = a;
    ifc.req_b[i*BW +: BW] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    rst  = 1'b1;
    halt = 1'b0;
    ifc.req_valid = '0;
    ifc.req_a = '0;
    ifc.req_b = '0;

    // Reset: grant blocked even with requests pending
    ifc.req_valid = 4'b1111;
    #1 chk("rst_ready", 128'(ifc.req_ready), 128'h0);
    step();
    chk("rst_ready2", 128'(ifc.req_ready), 128'h0);
    chk("rst_rvalid", 128'(ifc.resp_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_count", 128'(op_count), 128'h0);
    chk("rst_data", ifc.resp_data, 128'h0);
    step();
    chk("rst_count_hold", 128'(op_count), 128'h0);

    // Single request: -3 * 5
    rst = 1'b0;
    ifc.req_valid = 4'b0001;
    set_op(0, -64'sd3, 64'sd5);
    #1 chk("single_ready", 128'(ifc.req_ready), 128'h1);
    step();
    ifc.req_valid = '0;
    chk("single_cnt", 128'(op_count), 128'h1);
    chk("single_busy1", 128'(busy), 128'h1);
    chk("single_rv0", 128'(ifc.resp_valid), 128'h0);
    step();
    chk("single_rv", 128'(ifc.resp_valid), 128'h1);
    chk("single_id", 128'(ifc.resp_id), 128'h0);
    chk("single_data", ifc.resp_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    step();
    chk("single_rv_off", 128'(ifc.resp_valid), 128'h0);
    chk("single_hold", ifc.resp_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    chk("single_busy0", 128'(busy), 128'h0);

    // Fairness: all four requesters, operand (i+1)*10 identifies the owner
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 64'(i + 1), 64'd10);
    ifc.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("fair_gnt%0d", k), 128'(ifc.req_ready), 128'(4'b0001 << (k % 4)));
      step();
      if (k >= 1) begin
        chk($sformatf("fair_id%0d", k), 128'(ifc.resp_id), 128'((k - 1) % 4));
        chk($sformatf("fair_dat%0d", k), ifc.resp_data, 128'(((k - 1) % 4 + 1) * 10));
      end
    end
    ifc.req_valid = '0;
    chk("fair_cnt", 128'(op_count), 128'd8);
    step();
    chk("fair_id_last", 128'(ifc.resp_id), 128'd3);
    chk("fair_rv_last", 128'(ifc.resp_valid), 128'h1);

    // Corner products
    do_reset();
    ifc.req_valid = 4'b0001;
    set_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    step();
    set_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    step();
    ifc.req_valid = '0;
    chk("corner_minmin", ifc.resp_data, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    step();
    chk("corner_maxmin", ifc.resp_data, 128'hC000_0000_0000_0000_8000_0000_0000_0000);
    chk("corner_rv", 128'(ifc.resp_valid), 128'h1);

    // Halt with one op in stage 1
    do_reset();
    ifc.req_valid = 4'b0010;
    set_op(1, 64'd7, 64'd6);
    step();
    halt = 1'b1;
    ifc.req_valid = 4'b1111;
    #1 chk("halt_ready", 128'(ifc.req_ready), 128'h0);
    chk("halt_busy", 128'(busy), 128'h1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ifc.resp_valid) pulses++;
      if (k == 0) chk("halt_data", ifc.resp_data, 128'd42);
    end
    chk("halt_pulses", 128'(pulses), 128'd1);
    chk("halt_busy0", 128'(busy), 128'h0);
    chk("halt_cnt", 128'(op_count), 128'd1);
    halt = 1'b0;
    #1 chk("halt_resume_gnt", 128'(ifc.req_ready), 128'b0100);
    step();
    ifc.req_valid = '0;
    chk("halt_resume_cnt", 128'(op_count), 128'd2);
    step();
    step();

    // Reset mid-flight
    do_reset();
    ifc.req_valid = 4'b0010;
    step();
    ifc.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_rv", 128'(ifc.resp_valid), 128'h0);
    chk("midrst_cnt", 128'(op_count), 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (ifc.resp_valid) pulses++;
    end
    chk("midrst_pulses", 128'(pulses), 128'd0);
    ifc.req_valid = 4'b1111;
    #1 chk("midrst_gnt", 128'(ifc.req_ready), 128'b0001);

    // Counter wrap
    ifc.req_valid = '0;
    force dut.op_count = 32'hFFFF_FFFF;
    #1 release dut.op_count;
    ifc.req_valid = 4'b0001;
    step();
    ifc.req_valid = '0;
    chk("wrap_cnt", 128'(op_count), 128'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 Parameter BWIDTH, default 64, operand width in bits; product width is 2*BWIDTH.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter IDW, default 2, requester index width; IDW = clog2(NREQ).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset: synchronous, active-high.
REQ-006 Port halt  input  1  when high, no new request is granted; in-flight operations complete.
REQ-007 Port req_valid  input  NREQ  bit i high = requester i presents an operand pair.
REQ-008 Port req_a  input  NREQ*BWIDTH  signed operand A of requester i at bits [i*BWIDTH +: BWIDTH].
REQ-009 Port req_b  input  NREQ*BWIDTH  signed operand B, same packing as req_a.
REQ-010 Port req_ready  output  NREQ  one-hot or zero grant; a transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-011 Port resp_valid  output  1  high for exactly one cycle per completed product.
REQ-012 Port resp_id  output  IDW  index of the requester that owns resp_data.
REQ-013 Port resp_data  output  2*BWIDTH  signed product A*B, full width, no truncation or saturation.
REQ-014 Port busy  output  1  high while any operation is in the pipeline (stage 1 or stage 2 valid).
REQ-015 Port op_count  output  32  number of accepted requests since reset, modulo 2^32.

Function
REQ-016 Arbitration is round-robin: a rotating pointer ptr selects the first i with req_valid[i] high, searching ptr, ptr+1, ... modulo NREQ.
REQ-017 req_ready is combinational from req_valid, ptr, halt and rst: at most one bit high; all bits low when halt=1, rst=1 or no req_valid bit is high.
REQ-018 On an accepting edge for requester g, ptr <= (g+1) mod NREQ; otherwise ptr holds.
REQ-019 At most one request is accepted per cycle; with no output backpressure, a request is accepted every cycle whenever any req_valid bit is high and halt=0.
REQ-020 Stage 1: on an accepting edge, register req_a/req_b slice g, id g, and s1_valid=1; otherwise s1_valid <= 0.
REQ-021 The stage-1 operands drive a signed BWIDTH x BWIDTH combinational multiply producing a 2*BWIDTH signed result.
REQ-022 Stage 2: each edge, resp_data <= product, resp_id <= s1_id, resp_valid <= s1_valid.
REQ-023 Latency is fixed: a request accepted on edge E appears with resp_valid=1 in the cycle after edge E+1 (2 cycles); throughput is 1 per cycle.
REQ-024 resp_data and resp_id hold their last values while resp_valid=0.
REQ-025 busy = s1_valid OR resp_valid.
REQ-026 op_count increments by 1 on each accepting edge; 0xFFFFFFFF wraps to 0.
REQ-027 If halt rises while stage 1 is full, that operation still completes on schedule; halt only blocks new grants.
REQ-028 A requester that drops req_valid without a transfer is not granted, and ptr does not advance.
REQ-029 Operands are treated as two's-complement: (-2^(BWIDTH-1)) * (-2^(BWIDTH-1)) = 2^(2*BWIDTH-2), exactly representable.

Reset
REQ-030 While rst=1, req_ready=0, and no transfer occurs.
REQ-031 On an edge with rst=1: ptr, s1_valid, resp_valid, op_count, resp_id and resp_data are all cleared to 0; busy reads 0 the next cycle.
REQ-032 rst asserted mid-operation discards all in-flight operations; no resp_valid pulse follows for them.

Verification
REQ-033 Single request: req_valid=0001, A=-3, B=5, accepted on edge E -> resp_valid=1 after E+1, resp_id=0, resp_data=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, op_count=1.
REQ-034 Fairness: all four req_valid held high for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; resp_id follows the same order 2 cycles later; op_count=8.
REQ-035 Corner product: A=B=0x8000_0000_0000_0000 -> resp_data=0x4000_0000_0000_0000_0000_0000_0000_0000; A=0x7FFF..., B=0x8000... -> 0xC000_0000_0000_0000_8000_0000_0000_0000.
REQ-036 Halt: halt=1 with requests pending and one op in stage 1 -> req_ready=0; exactly one resp_valid pulse follows; busy goes 1 then 0; op_count is unchanged until halt=0.
REQ-037 Reset mid-flight: accept on edge E, rst=1 on edge E+1 -> no resp_valid pulse; op_count=0; ptr=0, so the next grant with req_valid=1111 goes to requester 0.
REQ-038 Counter wrap: op_count is forced or run to 0xFFFFFFFF, then one more accept -> op_count=0.
